// File: rtl/detect_sequence_programmable.sv
// Programmable serial pattern detector (2..MAX_LEN bits) with overlap control and saturating match counter.
// detected is registered: it pulses in the cycle after the edge that samples the completing bit.
module detect_sequence_programmable #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         a,
    input  logic                         a_vld,
    input  logic                         cfg_load,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic                         clr_count,
    output logic                         detected,
    output logic [CNT_W-1:0]             match_count,
    output logic                         cfg_err,
    output logic                         armed
);
    localparam int                LEN_W   = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0]  LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]  LEN_MIN = LEN_W'(2);
    localparam logic [CNT_W-1:0]  CNT_SAT = '1;

    typedef enum logic {
        S_UNCFG = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [MAX_LEN-1:0] r_pat;
    // The newest bit comes straight from a, so only MAX_LEN-1 older bits are stored.
    logic [MAX_LEN-2:0] r_hist;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_fill;
    logic               r_ovl;
    logic               r_det;
    logic               r_err;
    logic [CNT_W-1:0]   r_cnt;

    logic [MAX_LEN-1:0] w_hist_nxt;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W-1:0]   w_fill_nxt;
    logic               w_legal;
    logic               w_load_ok;
    logic               w_shift;
    logic               w_match;

    assign w_legal    = (cfg_len >= LEN_MIN) && (cfg_len <= LEN_MAX);
    assign w_load_ok  = cfg_load && w_legal;
    // Any load in the same cycle as a valid bit takes priority and drops the bit.
    assign w_shift    = (r_state == S_RUN) && a_vld && !cfg_load;
    assign w_hist_nxt = {r_hist, a};
    assign w_fill_nxt = (r_fill == LEN_MAX) ? r_fill : r_fill + 1'b1;
    assign w_mask     = (MAX_LEN'(1) << r_len) - MAX_LEN'(1);
    assign w_match    = w_shift && (w_fill_nxt >= r_len)
                        && (((w_hist_nxt ^ r_pat) & w_mask) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_UNCFG;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_load_ok) begin
            w_state_nxt = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat  <= '0;
            r_hist <= '0;
            r_len  <= '0;
            r_fill <= '0;
            r_ovl  <= 1'b0;
            r_det  <= 1'b0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_det <= w_match;
            r_err <= cfg_load && !w_legal;
            if (w_load_ok) begin
                r_pat  <= cfg_pattern;
                r_len  <= cfg_len;
                r_ovl  <= cfg_overlap;
                r_hist <= '0;
                r_fill <= '0;
            end else if (w_shift) begin
                r_hist <= w_hist_nxt[MAX_LEN-2:0];
                r_fill <= (w_match && !r_ovl) ? '0 : w_fill_nxt;
            end
            if (clr_count) begin
                r_cnt <= w_match ? CNT_W'(1) : '0;
            end else if (w_match && (r_cnt != CNT_SAT)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign detected    = r_det;
    assign match_count = r_cnt;
    assign cfg_err     = r_err;
    assign armed       = (r_state == S_RUN);

endmodule
